// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU sources, the arbiter and the register-file write port.
// The arbiter uses the slave modport; the environment driving writebacks uses master.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  localparam int unsigned NREG = 1 << REG_ADDR_W;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_data;
  logic [NREG-1:0]       pending;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_we, rf_rd, rf_data, pending
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_we, rf_rd, rf_data, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between ALU and LSU writebacks using
// 1-entry buffers per source, oldest-first issue, x0 dropping and a pending-rd mask.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned NREG = 1 << REG_ADDR_W;

  logic                  alu_full, lsu_full;
  logic [REG_ADDR_W-1:0] alu_rd_q, lsu_rd_q;
  logic [XLEN-1:0]       alu_data_q, lsu_data_q;
  logic                  lsu_older;

  logic alu_gnt, lsu_gnt;
  logic alu_load, lsu_load;
  logic alu_full_nxt, lsu_full_nxt;
  logic lsu_older_nxt;

  always_comb begin
    alu_gnt = alu_full && (!lsu_full || !lsu_older);
    lsu_gnt = lsu_full && (!alu_full ||  lsu_older);
  end

  assign bus.alu_ready = !alu_full || alu_gnt;
  assign bus.lsu_ready = !lsu_full || lsu_gnt;

  // x0 writes complete the handshake but never occupy a buffer.
  assign alu_load = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
  assign lsu_load = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);

  always_comb begin
    alu_full_nxt  = alu_load || (alu_full && !alu_gnt);
    lsu_full_nxt  = lsu_load || (lsu_full && !lsu_gnt);
    lsu_older_nxt = lsu_older;
    if (alu_load && lsu_load)
      lsu_older_nxt = 1'b1;
    else if (alu_load && lsu_full_nxt)
      lsu_older_nxt = 1'b1;
    else if (lsu_load && alu_full_nxt)
      lsu_older_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_full   <= 1'b0;
      lsu_full   <= 1'b0;
      alu_rd_q   <= '0;
      lsu_rd_q   <= '0;
      alu_data_q <= '0;
      lsu_data_q <= '0;
      lsu_older  <= 1'b0;
    end else begin
      alu_full  <= alu_full_nxt;
      lsu_full  <= lsu_full_nxt;
      lsu_older <= lsu_older_nxt;
      if (alu_load) begin
        alu_rd_q   <= bus.alu_rd;
        alu_data_q <= bus.alu_data;
      end
      if (lsu_load) begin
        lsu_rd_q   <= bus.lsu_rd;
        lsu_data_q <= bus.lsu_data;
      end
    end
  end

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_rd   = '0;
    bus.rf_data = '0;
    if (lsu_gnt) begin
      bus.rf_we   = 1'b1;
      bus.rf_rd   = lsu_rd_q;
      bus.rf_data = lsu_data_q;
    end else if (alu_gnt) begin
      bus.rf_we   = 1'b1;
      bus.rf_rd   = alu_rd_q;
      bus.rf_data = alu_data_q;
    end
  end

  always_comb begin
    bus.pending = '0;
    if (alu_full) bus.pending[alu_rd_q] = 1'b1;
    if (lsu_full) bus.pending[lsu_rd_q] = 1'b1;
    bus.pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: cycle model with sequence-number
// ages, expected-write scoreboard queue and a shadow register file.
module tb_regfile_wb_arbiter;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: index 0 = ALU, 1 = LSU; smaller sequence number = older entry.
  bit          m_full [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_data [2];
  int          m_seq  [2];
  bit          m_rdy  [2];
  int          m_gnt;
  int          seq_ctr = 0;

  wr_t         exp_q[$];
  logic [31:0] shadow [32];
  int          dut_writes = 0;
  int          alu_wait = 0, lsu_wait = 0, max_wait = 0;

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_full[s] = 1'b0;
      m_rdy[s]  = 1'b1;
    end
    m_gnt = -1;
    exp_q.delete();
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
    bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ld;
  endtask

  task automatic sample();
    logic [31:0] mask;
    wr_t e;
    m_gnt = -1;
    if (m_full[0] && m_full[1]) m_gnt = (m_seq[1] < m_seq[0]) ? 1 : 0;
    else if (m_full[0])         m_gnt = 0;
    else if (m_full[1])         m_gnt = 1;
    for (int s = 0; s < 2; s++) m_rdy[s] = !m_full[s] || (m_gnt == s);
    mask = '0;
    for (int s = 0; s < 2; s++) if (m_full[s]) mask[m_rd[s]] = 1'b1;
    mask[0] = 1'b0;

    check("rf_we", 64'(bus.rf_we), 64'(m_gnt >= 0));
    check("alu_ready", 64'(bus.alu_ready), 64'(m_rdy[0]));
    check("lsu_ready", 64'(bus.lsu_ready), 64'(m_rdy[1]));
    check("pending", 64'(bus.pending), 64'(mask));
    if (m_gnt >= 0) exp_q.push_back('{rd: m_rd[m_gnt], data: m_data[m_gnt]});
    if (bus.rf_we) begin
      dut_writes++;
      if (exp_q.size() == 0) check("unexpected_write", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("wr_rd", 64'(bus.rf_rd), 64'(e.rd));
        check("wr_data", 64'(bus.rf_data), 64'(e.data));
      end
      shadow[bus.rf_rd] = bus.rf_data;
    end else begin
      check("idle_rd", 64'(bus.rf_rd), 64'(0));
      check("idle_data", 64'(bus.rf_data), 64'(0));
    end
    alu_wait = (bus.alu_valid && !bus.alu_ready) ? alu_wait + 1 : 0;
    lsu_wait = (bus.lsu_valid && !bus.lsu_ready) ? lsu_wait + 1 : 0;
    if (alu_wait > max_wait) max_wait = alu_wait;
    if (lsu_wait > max_wait) max_wait = lsu_wait;
  endtask

  task automatic model_update();
    bit xfer [2];
    xfer[0] = bus.alu_valid && m_rdy[0];
    xfer[1] = bus.lsu_valid && m_rdy[1];
    if (m_gnt >= 0) m_full[m_gnt] = 1'b0;
    // LSU takes the earlier sequence number so it wins same-edge ties.
    if (xfer[1] && bus.lsu_rd != 5'd0) begin
      m_full[1] = 1'b1; m_rd[1] = bus.lsu_rd; m_data[1] = bus.lsu_data; m_seq[1] = seq_ctr++;
    end
    if (xfer[0] && bus.alu_rd != 5'd0) begin
      m_full[0] = 1'b1; m_rd[0] = bus.alu_rd; m_data[0] = bus.alu_data; m_seq[0] = seq_ctr++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    sample();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rf_we"}, 64'(bus.rf_we), 64'(0));
    check({tag, "_rf_rd"}, 64'(bus.rf_rd), 64'(0));
    check({tag, "_rf_data"}, 64'(bus.rf_data), 64'(0));
    check({tag, "_pending"}, 64'(bus.pending), 64'(0));
    check({tag, "_alu_ready"}, 64'(bus.alu_ready), 64'(1));
    check({tag, "_lsu_ready"}, 64'(bus.lsu_ready), 64'(1));
  endtask

  initial begin
    int prev_src;
    for (int r = 0; r < 32; r++) shadow[r] = '0;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    #2;
    check_reset("por");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    sample();

    // Single ALU write
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("t2_rf_rd", 64'(bus.rf_rd), 64'(5));
    check("t2_pend5_set", 64'(bus.pending[5]), 64'(1));
    step();
    check("t2_pend5_clr", 64'(bus.pending[5]), 64'(0));

    // Collision: LSU first, ALU one cycle later
    drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("t3_first_rd", 64'(bus.rf_rd), 64'(4));
    check("t3_alu_stall", 64'(bus.alu_ready), 64'(0));
    step();
    check("t3_second_rd", 64'(bus.rf_rd), 64'(3));
    step();

    // WAW on x7 with both buffers contending
    drive(1, 5'd9, 32'h99, 1, 5'd10, 32'h1010);
    step();
    drive(0, 0, 0, 1, 5'd7, 32'hAA);
    step();
    drive(1, 5'd7, 32'hBB, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    check("t4_x7_final", 64'(shadow[7]), 64'(32'hBB));

    // Same-edge WAW: LSU is the older entry, ALU value survives
    drive(1, 5'd7, 32'hCC, 1, 5'd7, 32'hDD);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    check("t4b_x7_final", 64'(shadow[7]), 64'(32'hCC));

    // x0 drop
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    check("t5_alu_ready", 64'(bus.alu_ready), 64'(1));
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("t5_no_we", 64'(bus.rf_we), 64'(0));
    check("t5_no_pend", 64'(bus.pending), 64'(0));
    step();

    // Saturation: both sources valid every cycle
    dut_writes = 0;
    max_wait   = 0;
    prev_src   = -1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'(1 + (i % 31)), 32'hA000_0000 | 32'(i),
            1, 5'(1 + ((i + 7) % 31)), 32'h5000_0000 | 32'(i));
      step();
      if (bus.rf_we) begin
        if (prev_src >= 0)
          check("t6_alternate", 64'(bus.rf_data[31]), 64'(prev_src == 0));
        prev_src = bus.rf_data[31] ? 1 : 0;
      end
    end
    check("t6_writes", 64'(dut_writes), 64'(20));
    check("t6_max_wait_le1", 64'(max_wait <= 1), 64'(1));

    // Mid-traffic reset with both buffers occupied
    drive(1, 5'd12, 32'h1212, 1, 5'd13, 32'h1313);
    step();
    rst = 1'b0;
    #1;
    check_reset("mid");
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    sample();
    step(); step();

    check("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
